// File: rtl/io_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : io_pkg
//  Description : Shared I/O-space definitions. Holds the word indices
//                (addr[7:2]) of the output and input ports, the bus word
//                width and the read-select decode used by the input block.
//  Revision    : 1.0 - initial release
// ============================================================================
package io_pkg;

    localparam int IO_WORD_W = 32;

    // Output-port indices, owned by the output register block
    localparam logic [5:0] IO_OUT_PORT0_IDX = 6'b100000;
    localparam logic [5:0] IO_OUT_PORT1_IDX = 6'b100001;

    // Input-port indices
    localparam logic [5:0] IO_IN_PORT0_IDX  = 6'b110000;  // C0h
    localparam logic [5:0] IO_IN_PORT1_IDX  = 6'b110001;  // C4h
    localparam logic [5:0] IO_IN_STATUS_IDX = 6'b110010;  // C8h

    typedef enum logic [1:0] {
        SEL_NONE   = 2'd0,
        SEL_PORT0  = 2'd1,
        SEL_PORT1  = 2'd2,
        SEL_STATUS = 2'd3
    } io_in_sel_e;

    // Word index -> read source; anything unmapped reads as zero
    function automatic io_in_sel_e io_in_decode(input logic [5:0] idx);
        io_in_sel_e sel;
        sel = SEL_NONE;
        if (idx == IO_IN_PORT0_IDX)
            sel = SEL_PORT0;
        else if (idx == IO_IN_PORT1_IDX)
            sel = SEL_PORT1;
        else if (idx == IO_IN_STATUS_IDX)
            sel = SEL_STATUS;
        return sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/io_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : io_debounce
//  Description : Two-flop synchronizer followed by a word-wide debouncer.
//                A synchronized word must stay unchanged for DEBOUNCE_CYCLES
//                consecutive cycles before it is copied into the stable word.
//  Ports       : io_clk  - clock, rising edge
//                clrn    - asynchronous active-low reset
//                in_word - asynchronous external word
//                stable  - debounced word (registered)
//                update  - high for the cycle whose edge loads a new,
//                          different value into stable
//  Revision    : 1.0 - initial release
// ============================================================================
module io_debounce #(
    parameter int WIDTH           = 32,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 3
) (
    input  logic             io_clk,
    input  logic             clrn,
    input  logic [WIDTH-1:0] in_word,
    output logic [WIDTH-1:0] stable,
    output logic             update
);

    localparam logic [CNT_W-1:0] C_CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] C_CNT_LOAD = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s2;
    logic [WIDTH-1:0] r_cand;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_stable;

    logic             w_match;
    logic             w_update;

    assign w_match  = (r_s2 == r_cand);
    // Load happens on the edge where the count would reach its limit. Only
    // a value different from the current stable word counts as an update,
    // so a bounce that settles back on the old value raises no event.
    assign w_update = w_match && (r_cnt == C_CNT_LOAD) && (r_cand != r_stable);

    always_ff @(posedge io_clk or negedge clrn) begin
        if (!clrn) begin
            r_s1     <= '0;
            r_s2     <= '0;
            r_cand   <= '0;
            r_cnt    <= '0;
            r_stable <= '0;
        end else begin
            // Per-bit synchronizer; bits may resolve on different cycles,
            // which the debounce window absorbs.
            r_s1 <= in_word;
            r_s2 <= r_s1;

            if (!w_match) begin
                r_cand <= r_s2;
                r_cnt  <= '0;
            end else if (r_cnt != C_CNT_MAX) begin
                r_cnt  <= r_cnt + 1'b1;
            end

            if (w_update)
                r_stable <= r_cand;
        end
    end

    assign stable = r_stable;
    assign update = w_update;

endmodule
`default_nettype wire

// File: rtl/io_input_sync_reg.sv
`default_nettype none
// ============================================================================
//  Module      : io_input_sync_reg
//  Description : Memory-mapped input-port block. Synchronizes and debounces
//                two external 32-bit words, exposes them on the word-
//                addressed I/O bus and keeps per-port sticky change flags
//                that drive an interrupt line.
//  Ports       : io_clk         - I/O clock, rising edge
//                clrn           - asynchronous active-low reset
//                addr           - CPU byte address, addr[7:2] decoded
//                read_io_enable - CPU read strobe for I/O space
//                in_port0/1     - asynchronous external input words
//                dataout        - registered read data (1-cycle latency)
//                irq            - high while any change flag is set
//  Map         : C0h stable0, C4h stable1, C8h {30'b0,chg1,chg0} (read
//                clears both flags), others read 0
//  Revision    : 1.0 - initial release
// ============================================================================
module io_input_sync_reg
    import io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 3
) (
    input  logic                 io_clk,
    input  logic                 clrn,
    input  logic [31:0]          addr,
    input  logic                 read_io_enable,
    input  logic [IO_WORD_W-1:0] in_port0,
    input  logic [IO_WORD_W-1:0] in_port1,
    output logic [IO_WORD_W-1:0] dataout,
    output logic                 irq
);

    logic [IO_WORD_W-1:0] w_stable0;
    logic [IO_WORD_W-1:0] w_stable1;
    logic                 w_update0;
    logic                 w_update1;
    logic                 w_status_rd;
    logic [IO_WORD_W-1:0] w_rd_mux;
    io_in_sel_e           w_sel;
    logic                 w_unused_addr;

    logic                 r_chg0;
    logic                 r_chg1;
    logic [IO_WORD_W-1:0] r_dataout;

    io_debounce #(
        .WIDTH           (IO_WORD_W),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_deb0 (
        .io_clk  (io_clk),
        .clrn    (clrn),
        .in_word (in_port0),
        .stable  (w_stable0),
        .update  (w_update0)
    );

    io_debounce #(
        .WIDTH           (IO_WORD_W),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_deb1 (
        .io_clk  (io_clk),
        .clrn    (clrn),
        .in_word (in_port1),
        .stable  (w_stable1),
        .update  (w_update1)
    );

    // Only the word index is decoded
    assign w_unused_addr = ^{addr[31:8], addr[1:0]};

    assign w_sel       = io_in_decode(addr[7:2]);
    assign w_status_rd = read_io_enable && (w_sel == SEL_STATUS);

    // Mux reads the registered state, so a word or flag updating on the
    // read edge returns its pre-update value.
    always_comb begin
        w_rd_mux = '0;
        case (w_sel)
            SEL_PORT0:  w_rd_mux = w_stable0;
            SEL_PORT1:  w_rd_mux = w_stable1;
            SEL_STATUS: w_rd_mux = {{(IO_WORD_W-2){1'b0}}, r_chg1, r_chg0};
            default:    w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge io_clk or negedge clrn) begin
        if (!clrn) begin
            r_chg0    <= 1'b0;
            r_chg1    <= 1'b0;
            r_dataout <= '0;
        end else begin
            // Set has priority over the read-clear so an event landing on
            // the status-read edge is not lost.
            if (w_update0)
                r_chg0 <= 1'b1;
            else if (w_status_rd)
                r_chg0 <= 1'b0;

            if (w_update1)
                r_chg1 <= 1'b1;
            else if (w_status_rd)
                r_chg1 <= 1'b0;

            if (read_io_enable)
                r_dataout <= w_rd_mux;
        end
    end

    assign dataout = r_dataout;
    assign irq     = r_chg0 | r_chg1;

endmodule
`default_nettype wire

// File: tb/tb_io_input_sync_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_io_input_sync_reg
//  Description : Directed self-checking bench for io_input_sync_reg with
//                DEBOUNCE_CYCLES = 4. Inputs change 1 ns after a rising edge;
//                outputs are sampled at the same point.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_io_input_sync_reg;

    logic        io_clk;
    logic        clrn;
    logic [31:0] addr;
    logic        read_io_enable;
    logic [31:0] in_port0;
    logic [31:0] in_port1;
    logic [31:0] dataout;
    logic        irq;

    int checks = 0;
    int errors = 0;

    io_input_sync_reg #(
        .DEBOUNCE_CYCLES (4),
        .CNT_W           (3)
    ) dut (
        .io_clk         (io_clk),
        .clrn           (clrn),
        .addr           (addr),
        .read_io_enable (read_io_enable),
        .in_port0       (in_port0),
        .in_port1       (in_port1),
        .dataout        (dataout),
        .irq            (irq)
    );

    initial io_clk = 1'b0;
    always #5 io_clk = ~io_clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge io_clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        clrn           = 1'b0;
        addr           = 32'h0;
        read_io_enable = 1'b0;
        in_port0       = 32'h0;
        in_port1       = 32'h0;

        // Reset state
        tick(3);
        check("rst_dataout", dataout, 32'h0);
        check("rst_irq", {31'b0, irq}, 32'h0);

        // Settle port0 at FFFF, then reset in the middle of a new debounce
        clrn           = 1'b1;
        in_port0       = 32'h0000_FFFF;
        read_io_enable = 1'b1;
        addr           = 32'h0000_00C0;
        tick(10);
        check("pre_rst_data", dataout, 32'h0000_FFFF);
        check("pre_rst_irq", {31'b0, irq}, 32'h1);
        in_port0 = 32'h0;
        tick(4);
        check("mid_deb_data", dataout, 32'h0000_FFFF);
        #2;
        clrn = 1'b0;
        #1;
        check("async_rst_data", dataout, 32'h0);
        check("async_rst_irq", {31'b0, irq}, 32'h0);
        tick(2);
        clrn = 1'b1;
        tick(10);
        check("post_rst_stable0", dataout, 32'h0);
        check("post_rst_irq", {31'b0, irq}, 32'h0);

        // 3-cycle glitch on port1 must never reach stable1 or chg1
        addr     = 32'h0000_00C4;
        in_port1 = 32'h1;
        tick(3);
        in_port1 = 32'h0;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            check("glitch_irq", {31'b0, irq}, 32'h0);
            check("glitch_stable1", dataout, 32'h0);
        end
        addr = 32'h0000_00C8;
        tick(1);
        check("glitch_status", dataout, 32'h0);

        // Latency: change before edge 1, stable0 loads at edge 7 and the
        // registered read shows it one edge later
        addr     = 32'h0000_00C0;
        in_port0 = 32'h0000_00A5;
        tick(6);
        check("lat_irq_e6", {31'b0, irq}, 32'h0);
        check("lat_data_e6", dataout, 32'h0);
        tick(1);
        check("lat_irq_e7", {31'b0, irq}, 32'h1);
        check("lat_data_e7", dataout, 32'h0);
        tick(1);
        check("lat_data_e8", dataout, 32'h0000_00A5);

        // Address map reads
        in_port1 = 32'h0000_003C;
        tick(10);
        addr = 32'h0000_00C4;
        tick(1);
        check("rd_c4", dataout, 32'h0000_003C);
        check("rd_keeps_irq", {31'b0, irq}, 32'h1);
        addr = 32'h0000_00C0;
        tick(1);
        check("rd_c0", dataout, 32'h0000_00A5);
        addr = 32'h0000_00C8;
        tick(1);
        check("rd_c8", dataout, 32'h0000_0003);
        check("rd_c8_clears_irq", {31'b0, irq}, 32'h0);
        addr = 32'h0000_00FC;
        tick(1);
        check("rd_fc", dataout, 32'h0);
        addr = 32'h0000_00C8;
        tick(1);
        check("rd_c8_again", dataout, 32'h0);

        // Status read on the same edge stable1 updates: set wins
        read_io_enable = 1'b0;
        in_port0       = 32'h0000_005A;
        tick(10);
        check("chg0_set_irq", {31'b0, irq}, 32'h1);
        in_port1 = 32'h0000_00C3;
        tick(6);
        read_io_enable = 1'b1;
        addr           = 32'h0000_00C8;
        tick(1);
        check("same_edge_status", dataout, 32'h0000_0001);
        check("same_edge_irq", {31'b0, irq}, 32'h1);
        tick(1);
        check("chg1_kept_chg0_clr", dataout, 32'h0000_0002);
        check("after_clr_irq", {31'b0, irq}, 32'h0);
        addr = 32'h0000_00C4;
        tick(1);
        check("rd_new_stable1", dataout, 32'h0000_00C3);

        // No strobe: dataout holds while the address wanders
        read_io_enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            case (i % 4)
                0:       addr = 32'h0000_00C0;
                1:       addr = 32'h0000_00C8;
                2:       addr = 32'h0000_00FC;
                default: addr = 32'hDEAD_BEC4;
            endcase
            tick(1);
            check("hold_dataout", dataout, 32'h0000_00C3);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
